au_dispatch: RTL and testbench
==============================

AU_DISPATCH -- requirements
Module: au_dispatch

Interface
REQ-001 Parameter W, default 24: operand/result width, sign-magnitude Q9.14.
REQ-002 Parameter FRAC, default 14: fraction bits; passed through only, no arithmetic here.
REQ-003 Parameter DEPTH, default 4: command FIFO entries, power of two, at least 2.
REQ-004 Parameter TAGW, default 4: command tag width.
REQ-005 clk  in  1  single clock; all state updates on rising edge.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 in_valid  in  1  command offered.
REQ-008 in_ready  out  1  command accepted when in_valid and in_ready are both high at a clock edge.
REQ-009 in_r, in_s, in_i  in  W each  operands R, S, I.
REQ-010 in_op  in  2  AU operation: 00 ADD, 01 SUB, 10 MUL, 11 DIV.
REQ-011 in_tag  in  TAGW  caller tag, returned with the result.
REQ-012 au_start  out  1  start pulse to the AU.
REQ-013 au_R, au_S, au_I  out  W each  registered operands driven to the AU.
REQ-014 au_ctl_d  out  2  registered operation code.
REQ-015 au_result  in  W  AU result.
REQ-016 au_done  in  1  AU completion pulse.
REQ-017 au_busy  in  1  AU busy flag.
REQ-018 out_valid  out  1  result available.
REQ-019 out_ready  in  1  consumer accepts the result.
REQ-020 out_result  out  W  captured AU result.
REQ-021 out_tag, out_op  out  TAGW, 2  tag and op of the completed command.
REQ-022 out_err  out  1  result invalid (timeout); see Configuration.
REQ-023 pending  out  log2(DEPTH)+1  FIFO occupancy.

Function
REQ-024 The FIFO shall store {r, s, i, op, tag} in order; in_ready = (pending != DEPTH).
- When full, no push occurs, even if a pop happens in the same cycle.
REQ-025 A push and a pop in the same cycle shall leave pending unchanged; pointers shall wrap modulo DEPTH.
REQ-026 The FSM shall have four states.
- IDLE: FIFO non-empty and au_busy=0 -> ISSUE. Load au_R/S/I/ctl_d from the FIFO head, pop it, and latch its tag and op.
- ISSUE: au_start=1 for exactly this one cycle -> WAIT.
- WAIT: au_done=1 -> HOLD. Capture au_result into out_result and set out_valid=1 on the same edge.
- HOLD: out_ready=1 -> IDLE, clearing out_valid on that edge.
REQ-027 au_start shall never be high outside ISSUE; at most one command shall be outstanding at the AU.
REQ-028 With an empty idle block, a push at edge N shall produce au_start high during cycle N+2.
REQ-029 out_valid shall go high the cycle after au_done is sampled high.
REQ-030 out_result, out_tag, out_op and out_err shall stay stable while out_valid=1 and out_ready=0.
REQ-031 au_done seen in any state other than WAIT shall be ignored.
REQ-032 Operands shall pass through unmodified; divide-by-zero and overflow are the AU's concern.

Reset
REQ-033 While rst is high, all of the following shall be 0: FIFO pointers, pending, au_start, au_R, au_S, au_I, au_ctl_d, out_valid, out_result, out_tag, out_op, out_err; the FSM shall be in IDLE.
REQ-034 in_ready shall be 1 after reset.
REQ-035 Reset mid-operation shall discard queued and in-flight commands; an au_done arriving after reset release shall be ignored (REQ-031).

Configuration
REQ-036 Macro AU_DISPATCH_TIMEOUT_EN.
- Defined: an 8-bit counter clears on entry to WAIT and increments each WAIT cycle. At count 127 without au_done, go to HOLD with out_result=0 and out_err=1, out_tag/out_op from the issued command.
- Undefined: no counter; out_err is tied to 0; WAIT persists until au_done.

Verification
REQ-037 ADD R=0x00C000, S=0x008000, tag 3; AU model returns 0x014000 one cycle after start -> out_result=0x014000, out_tag=3, out_op=00, out_err=0.
REQ-038 DIV R=0x004000, S=0x008000; model asserts done 24 cycles after start with 0x002000 -> out_valid one cycle after done, exactly one au_start pulse.
REQ-039 Push 5 commands back-to-back with DEPTH=4 and au_busy held high -> in_ready low after 4 accepts, pending=4; results drain in push order with tags 0..3.
REQ-040 out_ready held low for 10 cycles with out_valid high -> outputs stable, no new au_start until acceptance.
REQ-041 rst pulsed during WAIT with 2 commands queued -> pending=0, out_valid=0, no au_start afterwards; a later au_done is ignored.
REQ-042 With AU_DISPATCH_TIMEOUT_EN defined, model never asserts done -> out_valid at WAIT cycle 128, out_err=1, out_result=0.

Source files
------------

// File: rtl/au_dispatch.sv
// ============================================================================
// Module   : au_dispatch
// Purpose  : Command FIFO and single-outstanding dispatcher for an arithmetic
//            unit (AU). Queues {R, S, I, op, tag}, issues one command at a
//            time with a start pulse, captures the result and holds it until
//            the consumer accepts it.
// Options  : AU_DISPATCH_TIMEOUT_EN - abort a command that the AU does not
//            complete within 128 WAIT cycles (result 0, out_err = 1).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module au_dispatch #(
    parameter int W     = 24,   // sign-magnitude Q9.14 operand width
    parameter int FRAC  = 14,   // fraction bits (informational only)
    parameter int DEPTH = 4,    // command FIFO entries, power of two
    parameter int TAGW  = 4     // caller tag width
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [W-1:0]             in_r,
    input  logic [W-1:0]             in_s,
    input  logic [W-1:0]             in_i,
    input  logic [1:0]               in_op,
    input  logic [TAGW-1:0]          in_tag,
    output logic                     au_start,
    output logic [W-1:0]             au_R,
    output logic [W-1:0]             au_S,
    output logic [W-1:0]             au_I,
    output logic [1:0]               au_ctl_d,
    input  logic [W-1:0]             au_result,
    input  logic                     au_done,
    input  logic                     au_busy,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [W-1:0]             out_result,
    output logic [TAGW-1:0]          out_tag,
    output logic [1:0]               out_op,
    output logic                     out_err,
    output logic [$clog2(DEPTH):0]   pending
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int EW = 3 * W + 2 + TAGW;

    // Reject parameter sets the pointer arithmetic cannot support.
    generate
        if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || FRAC < 0 || FRAC >= W) begin : g_param_chk
            $error("au_dispatch: DEPTH must be a power of two >= 2 and FRAC < W");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_HOLD  = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_next;

    logic [EW-1:0]    r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [PW-1:0]    r_pending;
    logic [W-1:0]     r_au_r, r_au_s, r_au_i;
    logic [1:0]       r_au_op;
    logic [TAGW-1:0]  r_cur_tag;
    logic [1:0]       r_cur_op;
    logic             r_out_valid;
    logic [W-1:0]     r_out_result;
    logic [TAGW-1:0]  r_out_tag;
    logic [1:0]       r_out_op;

    logic             w_full, w_empty, w_push, w_pop, w_done, w_tmo;
    logic [EW-1:0]    w_head;

    // A full FIFO never pushes, even when a pop happens on the same edge.
    assign w_full   = (r_pending == PW'(DEPTH));
    assign w_empty  = (r_pending == '0);
    assign w_push   = in_valid && !w_full;
    assign w_pop    = (r_state == S_IDLE) && !w_empty && !au_busy;
    assign w_head   = r_mem[r_rptr];
    assign w_done   = (r_state == S_WAIT) && au_done;

`ifdef AU_DISPATCH_TIMEOUT_EN
    logic [7:0] r_tmo_cnt;
    logic       r_err;

    assign w_tmo   = (r_state == S_WAIT) && !au_done && (r_tmo_cnt == 8'd127);
    assign out_err = r_err;

    // WAIT-cycle counter: cleared while issuing so it starts at 0 on WAIT entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tmo_cnt <= 8'd0;
        end else if (r_state == S_ISSUE) begin
            r_tmo_cnt <= 8'd0;
        end else if (r_state == S_WAIT) begin
            r_tmo_cnt <= r_tmo_cnt + 8'd1;
        end
    end

    // Error flag accompanies the result: set on timeout, cleared on a real completion.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (w_done) begin
            r_err <= 1'b0;
        end else if (w_tmo) begin
            r_err <= 1'b1;
        end
    end
`else
    assign w_tmo   = 1'b0;
    assign out_err = 1'b0;
`endif

    // FIFO storage; contents need no reset since pointers define validity.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= {in_r, in_s, in_i, in_op, in_tag};
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_pending <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + AW'(1);
            if (w_pop)  r_rptr <= r_rptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_pending <= r_pending + PW'(1);
                2'b01:   r_pending <= r_pending - PW'(1);
                default: r_pending <= r_pending;
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // FSM next-state logic; au_done outside WAIT has no effect.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_pop)              w_next = S_ISSUE;
            S_ISSUE:                         w_next = S_WAIT;
            S_WAIT:  if (au_done || w_tmo)   w_next = S_HOLD;
            S_HOLD:  if (out_ready)          w_next = S_IDLE;
            default:                         w_next = S_IDLE;
        endcase
    end

    // Operand/command registers loaded from the FIFO head when it is popped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_au_r    <= '0;
            r_au_s    <= '0;
            r_au_i    <= '0;
            r_au_op   <= 2'b00;
            r_cur_tag <= '0;
            r_cur_op  <= 2'b00;
        end else if (w_pop) begin
            r_au_r    <= w_head[EW-1 -: W];
            r_au_s    <= w_head[EW-1-W -: W];
            r_au_i    <= w_head[EW-1-2*W -: W];
            r_au_op   <= w_head[TAGW+1 -: 2];
            r_cur_tag <= w_head[TAGW-1:0];
            r_cur_op  <= w_head[TAGW+1 -: 2];
        end
    end

    // Result capture on completion (or timeout) and release on acceptance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid  <= 1'b0;
            r_out_result <= '0;
            r_out_tag    <= '0;
            r_out_op     <= 2'b00;
        end else if (w_done || w_tmo) begin
            r_out_valid  <= 1'b1;
            r_out_result <= w_done ? au_result : '0;
            r_out_tag    <= r_cur_tag;
            r_out_op     <= r_cur_op;
        end else if ((r_state == S_HOLD) && out_ready) begin
            r_out_valid  <= 1'b0;
        end
    end

    assign in_ready   = !w_full;
    assign pending    = r_pending;
    assign au_start   = (r_state == S_ISSUE);
    assign au_R       = r_au_r;
    assign au_S       = r_au_s;
    assign au_I       = r_au_i;
    assign au_ctl_d   = r_au_op;
    assign out_valid  = r_out_valid;
    assign out_result = r_out_result;
    assign out_tag    = r_out_tag;
    assign out_op     = r_out_op;

endmodule

`default_nettype wire

// File: tb/tb_au_dispatch.sv
// ============================================================================
// Module   : tb_au_dispatch
// Purpose  : Directed, table-driven bench for au_dispatch with a simple
//            fixed-latency AU model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_au_dispatch;

    localparam int W = 24, TAGW = 4, DEPTH = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [W-1:0]    in_r = '0, in_s = '0, in_i = '0;
    logic [1:0]      in_op = 2'b00;
    logic [TAGW-1:0] in_tag = '0;
    logic            au_start;
    logic [W-1:0]    au_R, au_S, au_I;
    logic [1:0]      au_ctl_d;
    logic [W-1:0]    au_result;
    logic            au_done, au_busy;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [W-1:0]    out_result;
    logic [TAGW-1:0] out_tag;
    logic [1:0]      out_op;
    logic            out_err;
    logic [2:0]      pending;

    au_dispatch #(.W(W), .FRAC(14), .DEPTH(DEPTH), .TAGW(TAGW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_r(in_r), .in_s(in_s), .in_i(in_i), .in_op(in_op), .in_tag(in_tag),
        .au_start(au_start), .au_R(au_R), .au_S(au_S), .au_I(au_I), .au_ctl_d(au_ctl_d),
        .au_result(au_result), .au_done(au_done), .au_busy(au_busy),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_tag(out_tag), .out_op(out_op), .out_err(out_err),
        .pending(pending)
    );

    always #5 clk = ~clk;

    // AU model: done pulses m_lat cycles after the cycle in which au_start is high.
    int           cyc = 0;
    int           n_start = 0;
    int           start_cyc = 0;
    int           m_cnt = 0;
    int           m_lat = 1;
    logic         m_done = 1'b0;
    logic         m_never = 1'b0;
    logic         inj_done = 1'b0;
    logic         force_busy = 1'b0;
    logic [W-1:0] m_res = '0;
    logic [W-1:0] cap_r = '0, cap_s = '0, cap_i = '0;
    logic [1:0]   cap_op = 2'b00;

    assign au_done   = m_done | inj_done;
    assign au_busy   = force_busy | (m_cnt != 0);
    assign au_result = m_res;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (au_start) begin
            n_start   <= n_start + 1;
            start_cyc <= cyc;
            m_cnt     <= m_lat;
            m_done    <= 1'b0;
            cap_r     <= au_R;
            cap_s     <= au_S;
            cap_i     <= au_I;
            cap_op    <= au_ctl_d;
        end else if (m_cnt > 0) begin
            m_cnt  <= m_cnt - 1;
            m_done <= (m_cnt == 1) && !m_never;
        end else begin
            m_done <= 1'b0;
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [1:0] op, input logic [W-1:0] r, input logic [W-1:0] s,
                        input logic [W-1:0] i, input logic [TAGW-1:0] tag, output int pcyc);
        @(negedge clk);
        in_op = op; in_r = r; in_s = s; in_i = i; in_tag = tag; in_valid = 1'b1;
        for (int k = 0; k < 200 && !in_ready; k++) @(negedge clk);
        if (!in_ready) begin
            n_tests++; n_fail++;
            $display("FAIL push_timeout: in_ready stayed 0 for tag %0d", tag);
        end
        pcyc = cyc;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_valid(input int budget, output int vcyc);
        for (int k = 0; k < budget && !out_valid; k++) @(negedge clk);
        if (!out_valid) begin
            n_tests++; n_fail++;
            $display("FAIL wait_valid_timeout: out_valid=0 after %0d cycles", budget);
        end
        vcyc = cyc;
    endtask

    task automatic accept();
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    typedef struct {
        logic [1:0]      op;
        logic [W-1:0]    r, s, i, res;
        logic [TAGW-1:0] tag;
        int              lat;
    } vec_t;

    vec_t vecs[4];

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int pcyc, vcyc, s0;
        logic stable, saw_valid;
        logic [4:0] rdy;

        vecs[0] = '{op: 2'b00, r: 24'h00C000, s: 24'h008000, i: 24'h000000, res: 24'h014000, tag: 4'd3,  lat: 1};
        vecs[1] = '{op: 2'b11, r: 24'h004000, s: 24'h008000, i: 24'h000001, res: 24'h002000, tag: 4'd5,  lat: 24};
        vecs[2] = '{op: 2'b01, r: 24'h800100, s: 24'h7FFFFF, i: 24'h00ABCD, res: 24'hABCDEF, tag: 4'd15, lat: 3};
        vecs[3] = '{op: 2'b10, r: 24'hFFFFFF, s: 24'h000000, i: 24'h123456, res: 24'h000000, tag: 4'd0,  lat: 2};

        // Reset state while rst is held high.
        repeat (3) @(negedge clk);
        chk("rst_pending",   128'(pending), 0);
        chk("rst_in_ready",  128'(in_ready), 1);
        chk("rst_au_start",  128'(au_start), 0);
        chk("rst_au_ops",    {au_R, au_S, au_I, au_ctl_d}, 0);
        chk("rst_out",       {out_valid, out_result, out_tag, out_op, out_err}, 0);
        rst = 1'b0;

        // Stray done in IDLE must be ignored.
        @(negedge clk); inj_done = 1'b1;
        @(negedge clk); inj_done = 1'b0;
        repeat (2) @(negedge clk);
        chk("stray_done_valid", 128'(out_valid), 0);
        chk("stray_done_start", 128'(n_start), 0);

        // Table-driven single commands.
        for (int v = 0; v < 4; v++) begin
            m_res = vecs[v].res;
            m_lat = vecs[v].lat;
            s0 = n_start;
            push(vecs[v].op, vecs[v].r, vecs[v].s, vecs[v].i, vecs[v].tag, pcyc);
            wait_valid(200, vcyc);
            chk($sformatf("v%0d_start_latency", v), 128'(start_cyc - pcyc), 2);
            chk($sformatf("v%0d_valid_latency", v), 128'(vcyc - start_cyc), 128'(vecs[v].lat + 1));
            chk($sformatf("v%0d_start_count", v),   128'(n_start - s0), 1);
            chk($sformatf("v%0d_au_operands", v),   {cap_r, cap_s, cap_i, cap_op},
                                                    {vecs[v].r, vecs[v].s, vecs[v].i, vecs[v].op});
            chk($sformatf("v%0d_result", v),        128'(out_result), 128'(vecs[v].res));
            chk($sformatf("v%0d_tag_op_err", v),    {out_tag, out_op, out_err}, {vecs[v].tag, vecs[v].op, 1'b0});
            accept();
        end

        // FIFO fill with AU busy: 4 accepts, 5th refused, then in-order drain.
        force_busy = 1'b1;
        m_lat = 2; m_res = 24'h000111;
        s0 = n_start;
        for (int t = 0; t < 5; t++) begin
            @(negedge clk);
            rdy[t] = in_ready;
            in_valid = 1'b1; in_tag = 4'(t); in_op = 2'(t); in_r = 24'(t);
        end
        @(negedge clk);
        in_valid = 1'b0;
        chk("fill_in_ready_seq", 128'(rdy), 128'(5'b01111));
        chk("fill_pending",      128'(pending), 4);
        chk("fill_in_ready_low", 128'(in_ready), 0);
        force_busy = 1'b0;
        for (int t = 0; t < 4; t++) begin
            wait_valid(100, vcyc);
            chk($sformatf("drain%0d_tag_op", t), {out_tag, out_op}, {4'(t), 2'(t)});
            chk($sformatf("drain%0d_result", t), 128'(out_result), 128'(24'h000111));
            accept();
        end
        repeat (10) @(negedge clk);
        chk("drain_no_fifth", {out_valid, pending}, 0);
        chk("drain_starts",   128'(n_start - s0), 4);

        // Back-pressure: outputs hold while out_ready is low; no new issue.
        m_lat = 1; m_res = 24'h123456;
        push(2'b10, 24'h001000, 24'h002000, 24'h0, 4'd7, pcyc);
        push(2'b01, 24'h003000, 24'h004000, 24'h0, 4'd8, pcyc);
        wait_valid(100, vcyc);
        s0 = n_start;
        stable = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (!(out_valid && out_result == 24'h123456 && out_tag == 4'd7 && out_op == 2'b10 && !out_err))
                stable = 1'b0;
        end
        chk("hold_outputs_stable", 128'(stable), 1);
        chk("hold_no_new_start",   128'(n_start - s0), 0);
        chk("hold_pending",        128'(pending), 1);
        accept();
        m_res = 24'h00FEED;
        wait_valid(100, vcyc);
        chk("hold_second_result", {out_result, out_tag, out_op}, {24'h00FEED, 4'd8, 2'b01});
        accept();

        // Reset during WAIT with two queued commands.
        m_lat = 40; m_res = 24'h0ABCDE;
        s0 = n_start;
        push(2'b11, 24'h1, 24'h2, 24'h3, 4'd1, pcyc);
        for (int k = 0; k < 50 && n_start == s0; k++) @(negedge clk);
        chk("rstwait_issued", 128'(n_start - s0), 1);
        push(2'b00, 24'h4, 24'h5, 24'h6, 4'd2, pcyc);
        push(2'b00, 24'h7, 24'h8, 24'h9, 4'd3, pcyc);
        @(negedge clk);
        chk("rstwait_queued", 128'(pending), 2);
        rst = 1'b1;
        @(negedge clk);
        chk("rstwait_cleared", {pending, out_valid, au_start, in_ready}, {3'd0, 1'b0, 1'b0, 1'b1});
        rst = 1'b0;
        s0 = n_start;
        saw_valid = 1'b0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (out_valid) saw_valid = 1'b1;
        end
        chk("rstwait_late_done_ignored", 128'(saw_valid), 0);
        chk("rstwait_no_start",          128'(n_start - s0), 0);

`ifdef AU_DISPATCH_TIMEOUT_EN
        // AU never completes: abort after 128 WAIT cycles.
        m_never = 1'b1; m_lat = 250; m_res = 24'h777777;
        push(2'b11, 24'h004000, 24'h0, 24'h0, 4'd9, pcyc);
        wait_valid(300, vcyc);
        chk("tmo_valid_latency", 128'(vcyc - start_cyc), 129);
        chk("tmo_outputs", {out_result, out_tag, out_op, out_err}, {24'h0, 4'd9, 2'b11, 1'b1});
        accept();
        m_never = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
